// File: rtl/triangle_sequencer.sv
// triangle_sequencer: turns one host burst command (count, height, sign,
// alternate) into a series of dav_/rfd handshakes toward the triangular
// pulse generator, with a programmable idle gap after each handshake.
module triangle_sequencer #(
  parameter int GAP = 4
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       cmd_dav_,
  output logic       cmd_rfd,
  input  logic [3:0] n_in,
  input  logic [6:0] h_in,
  input  logic       s_in,
  input  logic       alt_in,
  output logic       dav_,
  input  logic       rfd,
  output logic       s,
  output logic [6:0] h,
  output logic       busy
);

  localparam logic [7:0] GAP_CNT = 8'(GAP);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    W_RFD,
    OFFER,
    GAP_W
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] n_reg, n_next;
  logic       alt_reg, alt_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       cmd_rfd_reg, cmd_rfd_next;
  logic       dav_reg, dav_next;
  logic       s_reg, s_next;
  logic [6:0] h_reg, h_next;
  logic       busy_reg, busy_next;

  // Every output comes straight from a register.
  assign cmd_rfd = cmd_rfd_reg;
  assign dav_    = dav_reg;
  assign s       = s_reg;
  assign h       = h_reg;
  assign busy    = busy_reg;

  // State and datapath registers; reset drops any burst in progress and
  // releases dav_ even if the generator is mid-handshake.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_reg   <= IDLE;
      n_reg       <= 4'd0;
      alt_reg     <= 1'b0;
      cnt_reg     <= 8'd0;
      cmd_rfd_reg <= 1'b1;
      dav_reg     <= 1'b1;
      s_reg       <= 1'b0;
      h_reg       <= 7'd0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      n_reg       <= n_next;
      alt_reg     <= alt_next;
      cnt_reg     <= cnt_next;
      cmd_rfd_reg <= cmd_rfd_next;
      dav_reg     <= dav_next;
      s_reg       <= s_next;
      h_reg       <= h_next;
      busy_reg    <= busy_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a state says otherwise.
  always_comb begin
    state_next   = state_reg;
    n_next       = n_reg;
    alt_next     = alt_reg;
    cnt_next     = cnt_reg;
    cmd_rfd_next = cmd_rfd_reg;
    dav_next     = dav_reg;
    s_next       = s_reg;
    h_next       = h_reg;
    busy_next    = busy_reg;

    unique case (state_reg)
      IDLE: begin
        cmd_rfd_next = 1'b1;
        if (!cmd_dav_) begin
          n_next       = n_in;
          h_next       = h_in;
          s_next       = s_in;
          alt_next     = alt_in;
          cmd_rfd_next = 1'b0;
          busy_next    = 1'b1;
          state_next   = ACK;
        end
      end

      ACK: begin
        // Host inputs are no longer looked at; only the release matters.
        if (cmd_dav_) begin
          if (n_reg == 4'd0) begin
            cmd_rfd_next = 1'b1;
            busy_next    = 1'b0;
            state_next   = IDLE;
          end else begin
            state_next = W_RFD;
          end
        end
      end

      W_RFD: begin
        dav_next = 1'b1;
        if (rfd) begin
          dav_next   = 1'b0;
          state_next = OFFER;
        end
      end

      OFFER: begin
        // s and h stay untouched while the request is outstanding.
        if (!rfd) begin
          dav_next   = 1'b1;
          n_next     = n_reg - 4'd1;
          s_next     = s_reg ^ alt_reg;
          cnt_next   = GAP_CNT;
          state_next = GAP_W;
        end
      end

      GAP_W: begin
        if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else if (n_reg == 4'd0) begin
          cmd_rfd_next = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end else begin
          state_next = W_RFD;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
